// File: rtl/block_hit_engine.sv
`default_nettype none
// ============================================================================
// Module      : block_hit_engine
// Description : Breakout-style block-state engine. Fills the block-state
//               memory, services collision hits (read-check-clear) and
//               tracks the number of blocks still standing.
// Revision    : 1.0 - initial release
// ============================================================================
module block_hit_engine #(
    parameter int NUM_BLOCKS = 85,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  HIT_REQ,
    input  logic [ADDR_WIDTH-1:0] HIT_ADDR,
    input  logic                  REFILL_REQ,
    output logic                  HIT_BUSY,
    output logic                  HIT_DONE,
    output logic                  HIT_RESULT,
    output logic [ADDR_WIDTH-1:0] BLOCKS_LEFT,
    output logic                  LEVEL_CLEAR,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    output logic                  MEM_WE,
    output logic                  MEM_WDATA,
    input  logic                  MEM_RDATA
);

    // Fill counter carries one extra bit so it can hold NUM_BLOCKS itself,
    // which marks "every address has been issued".
    localparam int                    c_cnt_w    = ADDR_WIDTH + 1;
    localparam logic [c_cnt_w-1:0]    c_fill_end = c_cnt_w'(NUM_BLOCKS);
    localparam logic [c_cnt_w-1:0]    c_cnt_one  = c_cnt_w'(1);
    localparam logic [ADDR_WIDTH-1:0] c_full     = ADDR_WIDTH'(NUM_BLOCKS);
    localparam logic [ADDR_WIDTH-1:0] c_one      = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        S_FILL = 3'd0,
        S_IDLE = 3'd1,
        S_RD   = 3'd2,
        S_CHK  = 3'd3,
        S_WR   = 3'd4
    } state_t;

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_fill_cnt;
    logic                 r_refill_pend;
    logic                 r_in_range;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state       <= S_FILL;
            r_fill_cnt    <= '0;
            r_refill_pend <= 1'b0;
            r_in_range    <= 1'b0;
            MEM_ADDR      <= '0;
            MEM_WE        <= 1'b0;
            MEM_WDATA     <= 1'b1;
            HIT_BUSY      <= 1'b1;
            HIT_DONE      <= 1'b0;
            HIT_RESULT    <= 1'b0;
            BLOCKS_LEFT   <= '0;
            LEVEL_CLEAR   <= 1'b0;
        end else begin
            HIT_DONE    <= 1'b0;
            LEVEL_CLEAR <= 1'b0;

            case (r_state)
                S_FILL: begin
                    if (r_fill_cnt == c_fill_end) begin
                        MEM_WE      <= 1'b0;
                        BLOCKS_LEFT <= c_full;
                        HIT_BUSY    <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        MEM_WE     <= 1'b1;
                        MEM_WDATA  <= 1'b1;
                        MEM_ADDR   <= r_fill_cnt[ADDR_WIDTH-1:0];
                        r_fill_cnt <= r_fill_cnt + c_cnt_one;
                    end
                end

                S_IDLE: begin
                    // A refill wins over a simultaneous hit; the hit is dropped.
                    if (REFILL_REQ || r_refill_pend) begin
                        r_refill_pend <= 1'b0;
                        r_fill_cnt    <= '0;
                        MEM_WE        <= 1'b0;
                        HIT_BUSY      <= 1'b1;
                        r_state       <= S_FILL;
                    end else if (HIT_REQ) begin
                        MEM_ADDR   <= HIT_ADDR;
                        MEM_WE     <= 1'b0;
                        HIT_BUSY   <= 1'b1;
                        r_in_range <= ({1'b0, HIT_ADDR} < c_fill_end);
                        r_state    <= S_RD;
                    end
                end

                S_RD: begin
                    if (REFILL_REQ) begin
                        r_refill_pend <= 1'b1;
                    end
                    r_state <= S_CHK;
                end

                S_CHK: begin
                    if (REFILL_REQ) begin
                        r_refill_pend <= 1'b1;
                    end
                    HIT_RESULT <= MEM_RDATA & r_in_range;
                    if (MEM_RDATA && r_in_range) begin
                        MEM_WE    <= 1'b1;
                        MEM_WDATA <= 1'b0;
                        if (BLOCKS_LEFT != '0) begin
                            BLOCKS_LEFT <= BLOCKS_LEFT - c_one;
                            if (BLOCKS_LEFT == c_one) begin
                                LEVEL_CLEAR <= 1'b1;
                            end
                        end
                    end
                    r_state <= S_WR;
                end

                S_WR: begin
                    if (REFILL_REQ) begin
                        r_refill_pend <= 1'b1;
                    end
                    MEM_WE   <= 1'b0;
                    HIT_DONE <= 1'b1;
                    HIT_BUSY <= 1'b0;
                    r_state  <= S_IDLE;
                end

                default: begin
                    r_fill_cnt <= '0;
                    MEM_WE     <= 1'b0;
                    HIT_BUSY   <= 1'b1;
                    r_state    <= S_FILL;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/block_hit_engine.md
BLOCK_HIT_ENGINE -- requirements
Module: block_hit_engine

Interface
- REQ-001 Parameter NUM_BLOCKS, default 85, number of valid block-state bits (addresses 0..NUM_BLOCKS-1).
- REQ-002 Parameter ADDR_WIDTH, default 7, width of every block address.
- REQ-003 CLK  in  1  single clock; all state changes on rising edge.
- REQ-004 RESET  in  1  asynchronous, active-high reset.
- REQ-005 HIT_REQ  in  1  collision request from ball logic; honoured only when HIT_BUSY=0.
- REQ-006 HIT_ADDR  in  ADDR_WIDTH  block address of the collision; sampled on the accepting edge.
- REQ-007 REFILL_REQ  in  1  level-restart request; restores all blocks to present.
- REQ-008 HIT_BUSY  out  1  engine not idle; requests ignored.
- REQ-009 HIT_DONE  out  1  one-cycle pulse; hit transaction complete.
- REQ-010 HIT_RESULT  out  1  1 = block was present and has been cleared; valid from HIT_DONE until next accept.
- REQ-011 BLOCKS_LEFT  out  ADDR_WIDTH  count of present blocks.
- REQ-012 LEVEL_CLEAR  out  1  one-cycle pulse when BLOCKS_LEFT goes 1 -> 0.
- REQ-013 MEM_ADDR  out  ADDR_WIDTH  address to block-state write/read port.
- REQ-014 MEM_WE  out  1  write enable to block-state port.
- REQ-015 MEM_WDATA  out  1  write data to block-state port.
- REQ-016 MEM_RDATA  in  1  registered read data; reflects the MEM_ADDR presented one edge earlier, old value on a same-edge write.

Function
- REQ-017 All outputs SHALL be registered.
- REQ-018 FSM states SHALL be FILL, IDLE, RD, CHK, WR.
- REQ-019 FILL: MEM_WE=1, MEM_WDATA=1, MEM_ADDR steps 0..NUM_BLOCKS-1, one address per cycle; after the last write BLOCKS_LEFT=NUM_BLOCKS, MEM_WE=0, -> IDLE.
- REQ-020 IDLE with REFILL_REQ=1 (or refill pending) SHALL enter FILL at address 0; REFILL_REQ has priority over a simultaneous HIT_REQ, which is dropped.
- REQ-021 IDLE with HIT_REQ=1 and no refill: accepting edge registers MEM_ADDR=HIT_ADDR, MEM_WE=0, HIT_BUSY=1, -> RD.
- REQ-022 RD: wait one edge for memory read -> CHK.
- REQ-023 CHK: HIT_RESULT<=MEM_RDATA; if MEM_RDATA=1, MEM_WE<=1, MEM_WDATA<=0, BLOCKS_LEFT decrements by 1; -> WR.
- REQ-024 WR: MEM_WE<=0, HIT_DONE<=1 for one cycle, HIT_BUSY<=0, -> IDLE; HIT_DONE thus rises 3 edges after the accepting edge.
- REQ-025 HIT_ADDR >= NUM_BLOCKS SHALL be accepted with identical timing, HIT_RESULT=0, no write, no count change.
- REQ-026 BLOCKS_LEFT SHALL never decrement below 0; LEVEL_CLEAR pulses on the edge it reaches 0 via a hit.
- REQ-027 REFILL_REQ seen in RD/CHK/WR SHALL be latched as pending and serviced from IDLE after HIT_DONE; in FILL it is ignored.
- REQ-028 HIT_BUSY SHALL be 1 in FILL, RD, CHK, WR and 0 in IDLE.

Reset
- REQ-029 RESET asserted SHALL immediately force: state FILL at address 0, MEM_ADDR=0, MEM_WE=0, MEM_WDATA=1, HIT_BUSY=1, HIT_DONE=0, HIT_RESULT=0, BLOCKS_LEFT=0, LEVEL_CLEAR=0, refill pending cleared.
- REQ-030 On release, FILL SHALL run to completion (writes on addresses 0..NUM_BLOCKS-1), so block state is consistent after every reset.
- REQ-031 RESET mid-transaction or mid-fill SHALL abandon it without HIT_DONE and restart FILL from address 0.

Verification
- REQ-032 Reset release -> exactly 85 writes of 1 to addresses 0..84 on consecutive cycles, then HIT_BUSY=0, BLOCKS_LEFT=85.
- REQ-033 HIT_REQ addr 10 (present) -> one write of 0 to addr 10, HIT_DONE 3 edges after accept, HIT_RESULT=1, BLOCKS_LEFT=84; repeat addr 10 -> HIT_RESULT=0, no write, BLOCKS_LEFT=84.
- REQ-034 HIT_REQ addr 100 -> HIT_RESULT=0, MEM_WE never 1, same latency.
- REQ-035 Clear all 85 blocks -> LEVEL_CLEAR pulses once on the 85th hit, BLOCKS_LEFT=0.
- REQ-036 REFILL_REQ during CHK -> hit completes with HIT_DONE, then FILL of 85 writes, BLOCKS_LEFT=85; simultaneous HIT_REQ+REFILL_REQ in IDLE -> FILL only.
- REQ-037 RESET pulse at fill address 40 -> MEM_WE drops asynchronously, fill restarts at address 0.
